// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one sequential divider between NUM_REQ requesters.
// Operands are latched on grant; zero divisors bypass the divider; WAIT is timeout-guarded.
module divider_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] divisor_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic [NUM_REQ-1:0]       result_valid_out,
  output logic [WIDTH-1:0]         quotient_out,
  output logic [WIDTH-1:0]         remainder_out,
  output logic                     error_out,
  output logic                     busy_out,
  output logic [WIDTH-1:0]         div_dividend_out,
  output logic [WIDTH-1:0]         div_divisor_out,
  output logic                     div_start_out,
  input  logic [WIDTH-1:0]         div_quotient_in,
  input  logic [WIDTH-1:0]         div_remainder_in,
  input  logic                     div_valid_in,
  input  logic                     div_error_in,
  input  logic                     div_busy_in
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int unsigned NREQ_U = NUM_REQ;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               error_q, error_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [WIDTH-1:0]   sel_dividend;
  logic [WIDTH-1:0]   sel_divisor;
  logic               grant_ok;
  int unsigned        cand;

  // First requester at or after the rr pointer, wrapping at NUM_REQ.
  always_comb begin
    grant_found  = 1'b0;
    grant_idx    = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    cand         = 0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NREQ_U) cand = cand - NREQ_U;
      if (!grant_found && req_valid_in[cand]) begin
        grant_found  = 1'b1;
        grant_idx    = cand[IDX_W-1:0];
        sel_dividend = dividend_in[cand*WIDTH +: WIDTH];
        sel_divisor  = divisor_in[cand*WIDTH +: WIDTH];
      end
    end
  end

  assign grant_ok = (state_q == ST_IDLE) && grant_found && !div_busy_in;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    error_d     = error_q;
    timer_d     = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_ok) begin
          grant_d    = grant_idx;
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          if (sel_divisor == '0) begin
            quotient_d  = '0;
            remainder_d = '0;
            error_d     = 1'b1;
            state_d     = ST_RESPOND;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A valid response takes priority over a simultaneous error.
        if (div_valid_in) begin
          quotient_d  = div_quotient_in;
          remainder_d = div_remainder_in;
          error_d     = div_error_in;
          state_d     = ST_RESPOND;
        end else if (div_error_in || timer_q == TMR_W'(TIMEOUT - 1)) begin
          quotient_d  = '0;
          remainder_d = '0;
          error_d     = 1'b1;
          state_d     = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        rr_d    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      error_q     <= error_d;
      timer_q     <= timer_d;
    end
  end

  // Ready is combinational, so it is gated by reset to keep all outputs low while held.
  assign req_ready_out    = (grant_ok && !rst_in) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign result_valid_out = (state_q == ST_RESPOND) ? (NUM_REQ'(1) << grant_q) : '0;
  assign quotient_out     = quotient_q;
  assign remainder_out    = remainder_q;
  assign error_out        = error_q;
  assign busy_out         = (state_q != ST_IDLE);
  assign div_dividend_out = dividend_q;
  assign div_divisor_out  = divisor_q;
  assign div_start_out    = (state_q == ST_ISSUE);

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a fixed-latency behavioural divider stub.
module tb_divider_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TO   = 8;

  logic              clk_in;
  logic              rst_in;
  logic [NREQ-1:0]   req_valid_in;
  logic [NREQ*W-1:0] dividend_in;
  logic [NREQ*W-1:0] divisor_in;
  logic [NREQ-1:0]   req_ready_out;
  logic [NREQ-1:0]   result_valid_out;
  logic [W-1:0]      quotient_out;
  logic [W-1:0]      remainder_out;
  logic              error_out;
  logic              busy_out;
  logic [W-1:0]      div_dividend_out;
  logic [W-1:0]      div_divisor_out;
  logic              div_start_out;
  logic [W-1:0]      div_quotient_in;
  logic [W-1:0]      div_remainder_in;
  logic              div_valid_in;
  logic              div_error_in;
  logic              div_busy_in;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        stub_en  = 1'b1;

  divider_arbiter #(
    .NUM_REQ (NREQ),
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .req_valid_in     (req_valid_in),
    .dividend_in      (dividend_in),
    .divisor_in       (divisor_in),
    .req_ready_out    (req_ready_out),
    .result_valid_out (result_valid_out),
    .quotient_out     (quotient_out),
    .remainder_out    (remainder_out),
    .error_out        (error_out),
    .busy_out         (busy_out),
    .div_dividend_out (div_dividend_out),
    .div_divisor_out  (div_divisor_out),
    .div_start_out    (div_start_out),
    .div_quotient_in  (div_quotient_in),
    .div_remainder_in (div_remainder_in),
    .div_valid_in     (div_valid_in),
    .div_error_in     (div_error_in),
    .div_busy_in      (div_busy_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Divider stub: answers three cycles after the start pulse; silent when stub_en is low.
  initial begin
    int unsigned cnt;
    logic [W-1:0] a, b;
    cnt = 0;
    a = '0;
    b = '0;
    div_valid_in     = 1'b0;
    div_error_in     = 1'b0;
    div_busy_in      = 1'b0;
    div_quotient_in  = '0;
    div_remainder_in = '0;
    forever begin
      @(posedge clk_in);
      #1;
      div_valid_in = 1'b0;
      if (rst_in) begin
        cnt = 0;
      end else if (cnt != 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          div_valid_in     = 1'b1;
          div_quotient_in  = a / b;
          div_remainder_in = a % b;
        end
      end else if (div_start_out && stub_en) begin
        a   = div_dividend_out;
        b   = div_divisor_out;
        cnt = 3;
      end
      div_busy_in = (cnt != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic set_op(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b);
    dividend_in[i*W +: W] = a;
    divisor_in[i*W +: W]  = b;
  endtask

  task automatic serve(input int unsigned g, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ee);
    int unsigned k;
    k = 0;
    while (req_ready_out == '0 && k < 100) begin
      step();
      k++;
    end
    check($sformatf("serve%0d_ready_in_time", g), 64'(k < 100), 64'd1);
    check($sformatf("serve%0d_ready", g), 64'(req_ready_out), 64'(1 << g));
    check($sformatf("serve%0d_busy_at_grant", g), 64'(busy_out), 64'd0);
    step();
    req_valid_in[g] = 1'b0;
    k = 0;
    while (result_valid_out == '0 && k < 100) begin
      step();
      k++;
    end
    check($sformatf("serve%0d_result_valid", g), 64'(result_valid_out), 64'(1 << g));
    check($sformatf("serve%0d_no_ready_overlap", g), 64'(req_ready_out), 64'd0);
    check($sformatf("serve%0d_quotient", g), 64'(quotient_out), 64'(eq));
    check($sformatf("serve%0d_remainder", g), 64'(remainder_out), 64'(er));
    check($sformatf("serve%0d_error", g), 64'(error_out), 64'(ee));
  endtask

  initial begin
    int unsigned k;
    int unsigned stray;
    rst_in       = 1'b1;
    req_valid_in = '0;
    dividend_in  = '0;
    divisor_in   = '0;

    // Reset state
    step();
    step();
    check("rst_ready", 64'(req_ready_out), 64'd0);
    check("rst_result_valid", 64'(result_valid_out), 64'd0);
    check("rst_quotient", 64'(quotient_out), 64'd0);
    check("rst_error", 64'(error_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_start", 64'(div_start_out), 64'd0);
    check("rst_div_dividend", 64'(div_dividend_out), 64'd0);

    // Single request 100/7
    rst_in = 1'b0;
    step();
    set_op(0, 32'd100, 32'd7);
    req_valid_in = 4'b0001;
    #1;
    check("t1_ready", 64'(req_ready_out), 64'd1);
    check("t1_busy_idle", 64'(busy_out), 64'd0);
    step();
    req_valid_in = '0;
    #1;
    check("t1_start", 64'(div_start_out), 64'd1);
    check("t1_div_dividend", 64'(div_dividend_out), 64'd100);
    check("t1_div_divisor", 64'(div_divisor_out), 64'd7);
    check("t1_ready_after", 64'(req_ready_out), 64'd0);
    k = 0;
    while (result_valid_out == '0 && k < 50) begin
      step();
      k++;
    end
    check("t1_latency", 64'(k), 64'd4);
    check("t1_result_valid", 64'(result_valid_out), 64'd1);
    check("t1_quotient", 64'(quotient_out), 64'd14);
    check("t1_remainder", 64'(remainder_out), 64'd2);
    check("t1_error", 64'(error_out), 64'd0);
    step();
    check("t1_pulse_once", 64'(result_valid_out), 64'd0);
    check("t1_idle", 64'(busy_out), 64'd0);
    check("t1_quotient_hold", 64'(quotient_out), 64'd14);

    // All four held from reset: grants in index order
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    set_op(0, 32'd50, 32'd3);
    set_op(1, 32'd60, 32'd4);
    set_op(2, 32'd70, 32'd5);
    set_op(3, 32'd80, 32'd6);
    req_valid_in = 4'b1111;
    #1;
    serve(0, 32'd16, 32'd2, 1'b0);
    serve(1, 32'd15, 32'd0, 1'b0);
    serve(2, 32'd14, 32'd0, 1'b0);
    serve(3, 32'd13, 32'd2, 1'b0);

    // Round-robin wrap: after 2, pending 1 and 3 give 3 then 1
    set_op(2, 32'd91, 32'd10);
    req_valid_in = 4'b0100;
    #1;
    serve(2, 32'd9, 32'd1, 1'b0);
    set_op(1, 32'd33, 32'd4);
    set_op(3, 32'd45, 32'd7);
    req_valid_in = req_valid_in | 4'b1010;
    #1;
    serve(3, 32'd6, 32'd3, 1'b0);
    serve(1, 32'd8, 32'd1, 1'b0);

    // Zero divisor bypass
    step();
    set_op(1, 32'd55, 32'd0);
    req_valid_in = 4'b0010;
    #1;
    check("t4_ready", 64'(req_ready_out), 64'h2);
    check("t4_start_grant", 64'(div_start_out), 64'd0);
    step();
    req_valid_in = '0;
    #1;
    check("t4_result_valid", 64'(result_valid_out), 64'h2);
    check("t4_error", 64'(error_out), 64'd1);
    check("t4_quotient", 64'(quotient_out), 64'd0);
    check("t4_remainder", 64'(remainder_out), 64'd0);
    check("t4_start_respond", 64'(div_start_out), 64'd0);
    check("t4_div_dividend", 64'(div_dividend_out), 64'd55);
    step();
    check("t4_start_after", 64'(div_start_out), 64'd0);
    check("t4_idle", 64'(busy_out), 64'd0);

    // Silent divider: timeout
    stub_en = 1'b0;
    set_op(0, 32'd9, 32'd3);
    req_valid_in = 4'b0001;
    #1;
    check("t5_ready", 64'(req_ready_out), 64'd1);
    step();
    req_valid_in = '0;
    #1;
    check("t5_start", 64'(div_start_out), 64'd1);
    k = 0;
    while (result_valid_out == '0 && k < 50) begin
      step();
      k++;
    end
    check("t5_timeout_latency", 64'(k), 64'(TO + 1));
    check("t5_result_valid", 64'(result_valid_out), 64'd1);
    check("t5_error", 64'(error_out), 64'd1);
    check("t5_quotient", 64'(quotient_out), 64'd0);
    check("t5_remainder", 64'(remainder_out), 64'd0);

    // Reset in the middle of WAIT
    step();
    set_op(2, 32'd20, 32'd4);
    req_valid_in = 4'b0100;
    #1;
    check("t6_ready", 64'(req_ready_out), 64'h4);
    step();
    req_valid_in = '0;
    #1;
    check("t6_start", 64'(div_start_out), 64'd1);
    step();
    step();
    check("t6_busy_wait", 64'(busy_out), 64'd1);
    rst_in = 1'b1;
    #1;
    check("t6_rst_busy", 64'(busy_out), 64'd0);
    check("t6_rst_error", 64'(error_out), 64'd0);
    check("t6_rst_result_valid", 64'(result_valid_out), 64'd0);
    check("t6_rst_div_dividend", 64'(div_dividend_out), 64'd0);
    check("t6_rst_start", 64'(div_start_out), 64'd0);
    step();
    step();
    rst_in = 1'b0;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (result_valid_out != '0) stray++;
    end
    check("t6_no_stray_result", 64'(stray), 64'd0);
    stub_en = 1'b1;
    set_op(3, 32'd81, 32'd9);
    req_valid_in = 4'b1000;
    #1;
    serve(3, 32'd9, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
